// File: rtl/store_buffer_if.sv
// Store-buffer bundle: CPU store/load ports and data-memory write/read ports.
// The slave modport is the buffer itself; the master modport is its environment.
interface store_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
);
  logic                      st_valid;
  logic [DATA_WIDTH-1:0]     st_addr;
  logic [DATA_WIDTH-1:0]     st_data;
  logic                      st_ready;
  logic [DATA_WIDTH-1:0]     ld_addr;
  logic [DATA_WIDTH-1:0]     ld_data;
  logic                      ld_hit;
  logic                      mem_we;
  logic [DATA_WIDTH-1:0]     mem_w_addr;
  logic [DATA_WIDTH-1:0]     mem_wd;
  logic                      mem_wready;
  logic [DATA_WIDTH-1:0]     mem_r_addr;
  logic [DATA_WIDTH-1:0]     mem_rd;
  logic [$clog2(DEPTH):0]    count;
  logic                      empty;

  modport slave (
    input  st_valid, st_addr, st_data, ld_addr, mem_wready, mem_rd,
    output st_ready, ld_data, ld_hit, mem_we, mem_w_addr, mem_wd,
           mem_r_addr, count, empty
  );

  modport master (
    output st_valid, st_addr, st_data, ld_addr, mem_wready, mem_rd,
    input  st_ready, ld_data, ld_hit, mem_we, mem_w_addr, mem_wd,
           mem_r_addr, count, empty
  );
endinterface

// File: rtl/store_buffer.sv
// Circular-FIFO store buffer draining into data memory, with optional load forwarding.
// Define SB_FWD_EN to build the youngest-match forwarding path; otherwise loads always read memory.
module store_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  store_buffer_if.slave sb
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

  logic [DATA_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [AW-1:0]         head_q, head_d;
  logic [AW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  enq_s, deq_s, empty_s, full_s;

  assign full_s  = (count_q == FULL_CNT);
  assign empty_s = (count_q == {CW{1'b0}});
  assign enq_s   = sb.st_valid && !full_s;
  assign deq_s   = !empty_s && sb.mem_wready;

  // Next-state pointers and occupancy; simultaneous enqueue and retire leave count unchanged.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq_s) begin
      tail_d = tail_q + PTR_ONE;
    end else begin
      tail_d = tail_q;
    end
    if (deq_s) begin
      head_d = head_q + PTR_ONE;
    end else begin
      head_d = head_q;
    end
    case ({enq_s, deq_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset discards every pending entry at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= {AW{1'b0}};
      tail_q  <= {AW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is left unreset: occupancy alone decides what may drain or forward.
  always_ff @(posedge clk) begin
    if (enq_s) begin
      addr_q[tail_q] <= sb.st_addr;
      data_q[tail_q] <= sb.st_data;
    end
  end

  assign sb.st_ready   = !full_s;
  assign sb.count      = count_q;
  assign sb.empty      = empty_s;
  assign sb.mem_we     = deq_s;
  assign sb.mem_w_addr = addr_q[head_q];
  assign sb.mem_wd     = data_q[head_q];
  assign sb.mem_r_addr = sb.ld_addr;

`ifdef SB_FWD_EN
  logic [DEPTH-1:0]      match_s;
  logic                  fwd_hit_s;
  logic [DATA_WIDTH-1:0] fwd_data_s;

  // Walk entries oldest to youngest so the youngest match wins; a same-cycle enqueue is not yet counted.
  always_comb begin
    match_s    = {DEPTH{1'b0}};
    fwd_hit_s  = 1'b0;
    fwd_data_s = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      match_s[i] = (CW'(i) < count_q) &&
                   (addr_q[head_q + AW'(i)] == sb.ld_addr);
      fwd_hit_s  = fwd_hit_s | match_s[i];
      fwd_data_s = match_s[i] ? data_q[head_q + AW'(i)] : fwd_data_s;
    end
  end

  assign sb.ld_hit  = fwd_hit_s;
  assign sb.ld_data = fwd_hit_s ? fwd_data_s : sb.mem_rd;
`else
  assign sb.ld_hit  = 1'b0;
  assign sb.ld_data = sb.mem_rd;
`endif

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of addresses and data.
REQ-002 Parameter DEPTH, default 4, SHALL set the number of entries; it SHALL be a power of two and at least 2.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  reset; it SHALL be asynchronous and active-low.
REQ-005 st_valid  in  1  CPU store request.
REQ-006 st_addr  in  DATA_WIDTH  CPU store address.
REQ-007 st_data  in  DATA_WIDTH  CPU store data.
REQ-008 st_ready  out  1  buffer accepts the store this cycle.
REQ-009 ld_addr  in  DATA_WIDTH  CPU load address.
REQ-010 ld_data  out  DATA_WIDTH  load result.
REQ-011 ld_hit  out  1  load result came from a buffer entry.
REQ-012 mem_we  out  1  write enable to the data memory.
REQ-013 mem_w_addr  out  DATA_WIDTH  memory write address.
REQ-014 mem_wd  out  DATA_WIDTH  memory write data.
REQ-015 mem_wready  in  1  memory can accept a write this cycle.
REQ-016 mem_r_addr  out  DATA_WIDTH  memory read address.
REQ-017 mem_rd  in  DATA_WIDTH  combinational memory read data.
REQ-018 count  out  $clog2(DEPTH)+1  number of occupied entries.
REQ-019 empty  out  1  count==0; this is the fence indicator.

Function
REQ-020 The buffer SHALL be a circular FIFO with head, tail, and count registers; both pointers SHALL wrap modulo DEPTH.
REQ-021 st_ready SHALL equal (count != DEPTH), with no same-cycle bypass when the buffer is full.
REQ-022 Enqueue on the edge when st_valid && st_ready: the entry is written at tail, tail increments, and count increments.
REQ-023 mem_we SHALL equal (!empty && mem_wready), and mem_w_addr/mem_wd SHALL present the head entry combinationally.
REQ-024 Retire on the edge when mem_we: head increments and count decrements; the memory captures that entry on the same edge.
REQ-025 When enqueue and retire occur in the same cycle, count SHALL be unchanged and both pointers SHALL advance.
REQ-026 When the buffer is empty and a store is enqueued, mem_we SHALL be 0 in that cycle; the earliest drain is the next cycle (1-cycle latency).
REQ-027 While mem_wready=0, the head SHALL hold, and entries SHALL keep accumulating until full.
REQ-028 mem_r_addr SHALL equal ld_addr at all times, as a combinational path.
REQ-029 Load data SHALL be selected combinationally.
- With forwarding enabled, ld_data SHALL be the data of the youngest occupied entry whose address equals ld_addr exactly, and ld_hit SHALL be 1.
- With no matching entry, ld_data SHALL be mem_rd and ld_hit SHALL be 0.
REQ-030 An entry retiring in the current cycle SHALL still be eligible for forwarding in that cycle.
REQ-031 A store being enqueued in the current cycle SHALL NOT forward until the next cycle.
REQ-032 There SHALL be no FSM beyond the pointer/count datapath, and the count SHALL never exceed DEPTH or underflow.

Reset
REQ-033 When rst_n is low, head, tail, and count SHALL clear to 0 immediately, independent of clk.
REQ-034 During reset, the outputs SHALL be: st_ready=1, empty=1, mem_we=0, and ld_hit=0.
REQ-035 Asserting reset mid-operation SHALL discard all pending entries without writing them, and no partial write SHALL occur.
REQ-036 Entry storage need not be reset, but stale contents SHALL never forward or drain.

Configuration
REQ-037 The macro SB_FWD_EN SHALL control load forwarding.
- Defined: the forwarding of REQ-029/030 SHALL be compiled in.
- Undefined: ld_data SHALL be mem_rd, ld_hit SHALL be constant 0, and no comparators SHALL be built.
- Software SHALL then wait for empty=1 before loading any address it has stored to.

Verification
REQ-038 Reset, then store (0x10,0xAAAA) with mem_wready=1 -> the next cycle shows mem_we=1, mem_w_addr=0x10, mem_wd=0xAAAA; the following cycle shows count=0 and empty=1.
REQ-039 mem_wready=0, then 5 stores with DEPTH=4 -> the first four are accepted, st_ready=0 and count=4 on the fifth; after mem_wready=1, the drain order is 1,2,3,4 over 4 cycles.
REQ-040 With SB_FWD_EN, stores (0x20,1) then (0x20,2) held with mem_wready=0, and ld_addr=0x20 -> ld_data=2, ld_hit=1; ld_addr=0x24 -> ld_data=mem_rd, ld_hit=0.
REQ-041 Full buffer with mem_wready=1 and st_valid=1 held -> one enqueue and one retire per cycle, count stays DEPTH-1/DEPTH steady, and pointers wrap past DEPTH-1 to 0 with correct data order.
REQ-042 Three entries pending, rst_n pulsed low between edges -> count=0 and empty=1 immediately, and no mem_we for the discarded entries.
REQ-043 Without SB_FWD_EN, repeat REQ-040 -> ld_data=mem_rd and ld_hit=0 in all cases.
